uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, meaning the inter-byte idle limit in clk cycles (used only with UBM_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: sampled on the clk rising edge, active when 0.
REQ-004 rx_data  input  8  received UART byte.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-006 tx_data  output  8  byte to transmit.
REQ-007 tx_start  output  1  one-cycle request to the UART transmitter.
REQ-008 tx_busy  input  1  UART transmitter busy (TX_STATUS).
REQ-009 rd  output  1  bus read strobe.
REQ-010 wr  output  1  bus write strobe.
REQ-011 addr  output  32  bus address.
REQ-012 wdata  output  32  bus write data.
REQ-013 rdata  input  32  bus read data; valid combinationally in the same cycle as rd.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 Block SHALL act as a UART-driven bus initiator toward the peripheral/memory bus (debug loader).
REQ-016 States SHALL be IDLE, ADDR, DATA, WRITE, READ, SEND, ACK.
REQ-017 IDLE + rx_valid + byte 0x57 ('W') -> ADDR with op=write; byte 0x52 ('R') -> ADDR with op=read; any other byte SHALL be discarded and the state SHALL stay IDLE.
REQ-018 ADDR: 4 rx_valid bytes SHALL be shifted in MSB first; after the 4th, go to DATA for a write or to READ for a read.
REQ-019 DATA: 4 rx_valid bytes SHALL be shifted into wdata MSB first; after the 4th, go to WRITE.
REQ-020 addr[1:0] SHALL be driven as 00 regardless of the received bits (word-aligned access).
REQ-021 WRITE: wr=1 for exactly one cycle with addr/wdata stable, then go to ACK.
REQ-022 READ: rd=1 for exactly one cycle; rdata SHALL be latched at the end of that cycle; then go to SEND with a byte index of 0.
REQ-023 SEND: 4 latched bytes SHALL be transmitted MSB first, then the state returns to IDLE.
REQ-024 ACK: byte 0x4B ('K') SHALL be transmitted, then the state returns to IDLE.
REQ-025 TX handshake: tx_start SHALL pulse for one cycle only when tx_busy=0, with tx_data held from that cycle until the next tx_start.
REQ-026 tx_busy SHALL be ignored in the cycle after a tx_start; the next start SHALL wait for tx_busy=0.
REQ-027 rx_valid in WRITE, READ, SEND or ACK SHALL be dropped with no state effect.
REQ-028 rd and wr SHALL never be high simultaneously and SHALL never be high outside READ/WRITE.
REQ-029 Byte counters SHALL be 2 bits, reset to 0 on every ADDR/DATA/SEND entry.

Reset
REQ-030 With reset=0 at a clk edge, the state SHALL go to IDLE, and rd, wr, tx_start and busy SHALL be 0.
REQ-031 Reset SHALL also clear addr, wdata, tx_data, the read latch and all counters to 0.
REQ-032 Reset mid-frame or mid-transmit SHALL abandon the frame; no further tx_start, rd or wr is issued.

Configuration
REQ-033 Macro UBM_TIMEOUT_EN defined: in ADDR or DATA, if TIMEOUT_CYCLES consecutive cycles pass without rx_valid, the state SHALL return to IDLE with no bus access and no TX byte.
REQ-034 The UBM_TIMEOUT_EN timeout counter SHALL restart on every accepted byte.
REQ-035 UBM_TIMEOUT_EN undefined: there SHALL be no timeout counter, and a partial frame waits indefinitely.

Verification
REQ-036 Write: bytes 57 10 00 00 07 DE AD BE EF -> one wr cycle, addr=0x10000004, wdata=0xDEADBEEF, then TX 0x4B.
REQ-037 Read: bytes 52 40 00 00 0C with rdata=0x12345678 -> one rd cycle, addr=0x4000000C, then TX 12 34 56 78 in order.
REQ-038 Bytes 0x00, 0xFF, 0x41 in IDLE -> no rd/wr/tx_start, busy stays 0.
REQ-039 tx_busy held 1 for 100 cycles after each start during a read response -> 4 starts, each only after tx_busy falls; extra rx bytes during SEND are ignored.
REQ-040 UBM_TIMEOUT_EN with TIMEOUT_CYCLES=16: send 57 10 then stall 20 cycles -> IDLE, no wr; then a full frame completes normally.
REQ-041 reset=0 for one cycle after the 3rd data byte of a write -> no wr, no ACK, outputs 0, and the next frame works.

Source files
------------

// File: rtl/uart_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_bus_master
// Description : UART-driven bus initiator (debug loader). Frames:
//                 'W' A3 A2 A1 A0 D3 D2 D1 D0 -> one bus write, replies 'K'
//                 'R' A3 A2 A1 A0             -> one bus read, replies D3..D0
//               Multi-byte fields travel MSB first; accesses are word aligned.
// Options     : define UBM_TIMEOUT_EN to abandon a partial frame after
//               TIMEOUT_CYCLES idle cycles in the address/data phase.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,      // synchronous, active low
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] ACK_BYTE  = 8'h4B;  // 'K'

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_SEND  = 3'd5,
        S_ACK   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        op_write;      // frame kind captured from the command byte
    logic [31:0] addr_q;        // raw shifted address, low bits masked on output
    logic [31:0] wdata_q;
    logic [31:0] rd_latch;      // read data captured at the end of the rd cycle
    logic [1:0]  byte_cnt;      // shared by ADDR, DATA and SEND
    logic [7:0]  tx_data_q;     // last byte handed to the transmitter
    logic        tx_guard;      // high the cycle after a start: tx_busy not yet valid

    logic        tx_fire;
    logic [7:0]  tx_byte;
    logic        timeout_hit;
    logic        frame_phase;

    assign frame_phase = (state == S_ADDR) || (state == S_DATA);

`ifdef UBM_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = frame_phase && !rx_valid
                         && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive idle cycles in the address/data phase; any byte restarts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (frame_phase && !rx_valid && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    // Without the timeout option a partial frame simply waits for more bytes.
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and transmit request; a start only goes out when the
    // transmitter reports idle and the post-start blind cycle has passed.
    always_comb begin
        state_nxt = state;
        tx_fire   = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            S_IDLE: begin
                if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid && (byte_cnt == 2'd3)) begin
                    state_nxt = op_write ? S_DATA : S_READ;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid && (byte_cnt == 2'd3)) begin
                    state_nxt = S_WRITE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: state_nxt = S_ACK;
            S_READ:  state_nxt = S_SEND;
            S_SEND: begin
                case (byte_cnt)
                    2'd0:    tx_byte = rd_latch[31:24];
                    2'd1:    tx_byte = rd_latch[23:16];
                    2'd2:    tx_byte = rd_latch[15:8];
                    default: tx_byte = rd_latch[7:0];
                endcase
                tx_fire = reset && !tx_busy && !tx_guard;
                if (tx_fire && (byte_cnt == 2'd3)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                tx_byte = ACK_BYTE;
                tx_fire = reset && !tx_busy && !tx_guard;
                if (tx_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath: command capture, address/data shifting, read latch, tx byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_latch  <= '0;
            byte_cnt  <= 2'd0;
            tx_data_q <= 8'h00;
            tx_guard  <= 1'b0;
        end else begin
            tx_guard <= tx_fire;
            if (tx_fire) begin
                tx_data_q <= tx_byte;
            end
            case (state)
                S_IDLE: begin
                    if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
                        op_write <= (rx_data == CMD_WRITE);
                        byte_cnt <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        addr_q   <= {addr_q[23:0], rx_data};
                        byte_cnt <= (byte_cnt == 2'd3) ? 2'd0 : byte_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        wdata_q  <= {wdata_q[23:0], rx_data};
                        byte_cnt <= (byte_cnt == 2'd3) ? 2'd0 : byte_cnt + 2'd1;
                    end
                end
                S_READ: begin
                    rd_latch <= rdata;
                    byte_cnt <= 2'd0;
                end
                S_SEND: begin
                    if (tx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus strobes come straight from the one-cycle access states and are
    // suppressed while reset is asserted so an abandoned frame never reaches the bus.
    assign rd       = (state == S_READ)  && reset;
    assign wr       = (state == S_WRITE) && reset;
    assign busy     = (state != S_IDLE);
    assign addr     = {addr_q[31:2], 2'b00};
    assign wdata    = wdata_q;
    assign tx_start = tx_fire;
    assign tx_data  = tx_fire ? tx_byte : tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_bus_master
// Description : Directed self-checking bench for uart_bus_master. A frame
//               table drives complete UART frames; hand sequences cover tx
//               back-pressure, partial frames and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: after each start, busy for busy_len cycles.
    int busy_len = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (!reset)                         busy_cnt <= 0;
        else if (tx_start && busy_len > 0)  busy_cnt <= busy_len;
        else if (busy_cnt > 0)              busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Bus / tx monitor, sampled mid-cycle.
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overlap_cnt = 0;
    int          busy_start_cnt = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [7:0]  txq[$];
    int          start_cyc[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr) begin wr_cnt = wr_cnt + 1; last_addr = addr; last_wdata = wdata; end
        if (rd) begin rd_cnt = rd_cnt + 1; last_addr = addr; end
        if (rd && wr) overlap_cnt = overlap_cnt + 1;
        if (tx_start) begin
            txq.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (tx_busy) busy_start_cnt = busy_start_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy) break;
            tick(1);
        end
        check(name, {31'h0, busy}, 32'h0);
    endtask

    typedef struct packed {
        logic [3:0]  n;          // number of rx bytes
        logic [79:0] bytes;      // first byte in [79:72]
        logic [31:0] rdata;
        logic [1:0]  exp_wr;
        logic [1:0]  exp_rd;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [2:0]  exp_ntx;
        logic [31:0] exp_tx;     // first tx byte in [31:24]
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wr0, rd0;
        vec_t v;
        logic [31:0] tx_exp;

        vecs[0] = '{4'd9,  80'h57_10_00_00_07_DE_AD_BE_EF_00, 32'h0, 2'd1, 2'd0,
                    32'h1000_0004, 32'hDEAD_BEEF, 3'd1, 32'h4B00_0000};
        vecs[1] = '{4'd5,  80'h52_40_00_00_0C_00_00_00_00_00, 32'h1234_5678, 2'd0, 2'd1,
                    32'h4000_000C, 32'h0, 3'd4, 32'h1234_5678};
        vecs[2] = '{4'd3,  80'h00_FF_41_00_00_00_00_00_00_00, 32'h0, 2'd0, 2'd0,
                    32'h0, 32'h0, 3'd0, 32'h0};
        vecs[3] = '{4'd9,  80'h57_00_00_00_03_00_00_00_01_00, 32'h0, 2'd1, 2'd0,
                    32'h0000_0000, 32'h0000_0001, 3'd1, 32'h4B00_0000};
        vecs[4] = '{4'd5,  80'h52_FF_FF_FF_FF_00_00_00_00_00, 32'hA55A_00FF, 2'd0, 2'd1,
                    32'hFFFF_FFFC, 32'h0, 3'd4, 32'hA55A_00FF};
        vecs[5] = '{4'd10, 80'h41_57_20_00_01_02_CA_FE_F0_0D, 32'h0, 2'd1, 2'd0,
                    32'h2000_0100, 32'hCAFE_F00D, 3'd1, 32'h4B00_0000};
        vecs[6] = '{4'd5,  80'h52_52_00_00_01_00_00_00_00_00, 32'h5752_4B00, 2'd0, 2'd1,
                    32'h5200_0000, 32'h0, 3'd4, 32'h5752_4B00};

        // Reset state
        tick(3);
        check("reset_strobes", {28'h0, rd, wr, tx_start, busy}, 32'h0);
        check("reset_addr", addr, 32'h0);
        check("reset_wdata", wdata, 32'h0);
        check("reset_tx_data", {24'h0, tx_data}, 32'h0);
        reset = 1'b1;
        tick(2);

        // Frame table
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            txq.delete();
            rdata = v.rdata;
            for (int k = 0; k < 10; k++) begin
                if (k < int'(v.n)) send_byte(v.bytes[79 - 8*k -: 8]);
            end
            wait_idle($sformatf("v%0d_idle", i), 2000);
            tick(2);
            check($sformatf("v%0d_wr_count", i), wr_cnt - wr0, {30'h0, v.exp_wr});
            check($sformatf("v%0d_rd_count", i), rd_cnt - rd0, {30'h0, v.exp_rd});
            if (v.exp_wr != 0 || v.exp_rd != 0)
                check($sformatf("v%0d_addr", i), last_addr, v.exp_addr);
            if (v.exp_wr != 0)
                check($sformatf("v%0d_wdata", i), last_wdata, v.exp_wdata);
            check($sformatf("v%0d_ntx", i), txq.size(), {29'h0, v.exp_ntx});
            tx_exp = v.exp_tx;
            for (int k = 0; k < int'(v.exp_ntx); k++) begin
                if (k < txq.size())
                    check($sformatf("v%0d_tx%0d", i, k), {24'h0, txq[k]}, {24'h0, tx_exp[31 - 8*k -: 8]});
            end
            if (v.exp_ntx != 0)
                check($sformatf("v%0d_tx_hold", i), {24'h0, tx_data},
                      {24'h0, tx_exp[31 - 8*(int'(v.exp_ntx) - 1) -: 8]});
            check($sformatf("v%0d_busy_end", i), {31'h0, busy}, 32'h0);
        end

        // Transmitter back-pressure with stray rx bytes during SEND
        busy_len = 100;
        txq.delete();
        start_cyc.delete();
        wr0 = wr_cnt;
        rdata = 32'hCAFE_F00D;
        send_byte(8'h52); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        tick(5);
        send_byte(8'h57); send_byte(8'h10);
        wait_idle("bp_idle", 2000);
        check("bp_ntx", txq.size(), 32'd4);
        if (txq.size() == 4) begin
            check("bp_bytes", {txq[0], txq[1], txq[2], txq[3]}, 32'hCAFE_F00D);
            for (int k = 1; k < 4; k++)
                check($sformatf("bp_gap%0d", k), start_cyc[k] - start_cyc[k-1], 32'd101);
        end
        check("bp_no_wr", wr_cnt - wr0, 32'd0);
        busy_len = 0;
        tick(110);

        // Partial frame stall
        wr0 = wr_cnt;
        txq.delete();
        send_byte(8'h57); send_byte(8'h10);
        tick(20);
`ifdef UBM_TIMEOUT_EN
        check("to_busy", {31'h0, busy}, 32'h0);
        check("to_no_wr", wr_cnt - wr0, 32'd0);
        check("to_no_tx", txq.size(), 32'd0);
        send_byte(8'h57); send_byte(8'h10);
`else
        tick(20);
        check("stall_busy", {31'h0, busy}, 32'h1);
`endif
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle("stall_idle", 200);
        check("stall_wr", wr_cnt - wr0, 32'd1);
        check("stall_addr", last_addr, 32'h1000_0008);
        check("stall_wdata", last_wdata, 32'h1122_3344);
        check("stall_tx", txq.size() == 1 ? {24'h0, txq[0]} : 32'hFFFF_FFFF, 32'h4B);

        // Reset after the third data byte of a write
        wr0 = wr_cnt;
        txq.delete();
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        reset = 1'b0;
        tick(1);
        check("mid_reset_strobes", {28'h0, rd, wr, tx_start, busy}, 32'h0);
        check("mid_reset_addr", addr, 32'h0);
        check("mid_reset_wdata", wdata, 32'h0);
        check("mid_reset_tx_data", {24'h0, tx_data}, 32'h0);
        reset = 1'b1;
        tick(20);
        check("mid_reset_no_wr", wr_cnt - wr0, 32'd0);
        check("mid_reset_no_tx", txq.size(), 32'd0);
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle("post_reset_idle", 200);
        tick(2);
        check("post_reset_wr", wr_cnt - wr0, 32'd1);
        check("post_reset_addr", last_addr, 32'h3000_0000);
        check("post_reset_wdata", last_wdata, 32'h1122_3344);
        check("post_reset_tx", txq.size() == 1 ? {24'h0, txq[0]} : 32'hFFFF_FFFF, 32'h4B);

        // Global invariants
        check("rd_wr_overlap", overlap_cnt, 32'd0);
        check("start_while_busy", busy_start_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
